// File: rtl/bus_arbiter_rr4.sv
// bus_arbiter_rr4: round-robin arbiter and sequencer for four 32-bit producers
// sharing one valid/ready output port through an internal MUX4X32D.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req[3:0]   request; req[i] held with d<i> stable until ack[i]
//   d0..d3     requester data words
//   out_ready  downstream accepts the word this cycle
//   lock[3:0]  burst-hold request (present only when ARB_LOCK_EN is defined)
//   grant[3:0] registered one-hot owner (zero when idle)
//   sel[1:0]   registered binary owner; drives the mux select
//   ack[3:0]   one-cycle completion pulse to the owner
//   out_valid  owner still requesting
//   dout       selected word
//   xfer_cnt   completed transfers, wraps 65535 -> 0
//
// Optional feature macro: ARB_LOCK_EN (burst lock; default build leaves it out).

module MUX4X32D (
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic [31:0] a2,
  input  logic [31:0] a3,
  input  logic [1:0]  s,
  output logic [31:0] y
);

  always_comb begin
    y = a0;
    unique case (s)
      2'd0: y = a0;
      2'd1: y = a1;
      2'd2: y = a2;
      2'd3: y = a3;
      default: y = a0;
    endcase
  end

endmodule

module bus_arbiter_rr4 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic             out_ready,
`ifdef ARB_LOCK_EN
  input  logic [3:0]       lock,
`endif
  output logic [3:0]       grant,
  output logic [1:0]       sel,
  output logic [3:0]       ack,
  output logic             out_valid,
  output logic [WIDTH-1:0] dout,
  output logic [15:0]      xfer_cnt
);

  localparam int NREQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [15:0]       cnt_q, cnt_d;

  logic              xfer;
  logic              hold_burst;
  logic [NREQ-1:0]   mask;
  logic [2:0]        pk;

  // Returns {found, index}: first set bit of mask scanning
  // base+1, base+2, base+3, base+4 (mod 4). The scan runs backwards so
  // the nearest candidate is the last one written and therefore wins.
  function automatic logic [2:0] pick(
    input logic [NREQ-1:0] m,
    input logic [1:0]      base
  );
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int k = NREQ; k >= 1; k--) begin
      idx = base + 2'(k);
      if (m[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Handshake view of the registered owner.
  assign out_valid = (|grant_q) & req[sel_q];
  assign xfer      = out_valid & out_ready;
  assign ack       = grant_q & {NREQ{xfer}};

  assign grant    = grant_q;
  assign sel      = sel_q;
  assign xfer_cnt = cnt_q;

  always_comb begin
    hold_burst = 1'b0;
`ifdef ARB_LOCK_EN
    // Lock only matters on a completing word; withdrawal drops out_valid
    // and therefore xfer, so it still releases the bus.
    hold_burst = xfer & lock[sel_q];
`endif
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    mask    = '0;
    pk      = '0;

    if (xfer) cnt_d = cnt_q + 16'd1;

    unique case (state_q)
      IDLE: begin
        pk = pick(req, ptr_q);
        if (pk[2]) begin
          state_d = GRANT;
          grant_d = onehot(pk[1:0]);
          sel_d   = pk[1:0];
        end
      end
      GRANT: begin
        if (!req[sel_q]) begin
          // Withdrawal: release, keep priority pointer.
          state_d = IDLE;
          grant_d = '0;
        end else if (xfer && !hold_burst) begin
          // Rotate past the owner and hand over with no bubble if
          // anyone else (including a req rising now) is waiting.
          ptr_d = sel_q;
          mask  = req & ~grant_q;
          pk    = pick(mask, sel_q);
          if (pk[2]) begin
            grant_d = onehot(pk[1:0]);
            sel_d   = pk[1:0];
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  MUX4X32D u_mux (
    .a0 (d0),
    .a1 (d1),
    .a2 (d2),
    .a3 (d3),
    .s  (sel_q),
    .y  (dout)
  );

endmodule

// File: tb/tb_bus_arbiter_rr4.sv
// Testbench for bus_arbiter_rr4: directed scenarios with a scoreboard
// of expected {ack, dout} per completed word.

module tb_bus_arbiter_rr4;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] d0, d1, d2, d3;
  logic        out_ready;
`ifdef ARB_LOCK_EN
  logic [3:0]  lock;
`endif
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic [3:0]  ack;
  logic        out_valid;
  logic [31:0] dout;
  logic [15:0] xfer_cnt;

  typedef struct packed {
    logic [3:0]  ack;
    logic [31:0] dout;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  bus_arbiter_rr4 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .out_ready (out_ready),
`ifdef ARB_LOCK_EN
    .lock      (lock),
`endif
    .grant     (grant),
    .sel       (sel),
    .ack       (ack),
    .out_valid (out_valid),
    .dout      (dout),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [31:0] d);
    exp_t e;
    e.ack  = a;
    e.dout = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req       = 4'b0000;
    out_ready = 1'b0;
`ifdef ARB_LOCK_EN
    lock      = 4'b0000;
`endif
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Monitor: every completed word must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: ack %b dout %h", ack, dout);
        end else begin
          e = exp_q.pop_front();
          check("mon_ack", {28'd0, ack}, {28'd0, e.ack});
          check("mon_dout", dout, e.dout);
        end
      end
    end
  end

  initial begin
    d0 = 32'h0; d1 = 32'h0; d2 = 32'h0; d3 = 32'h0;
    do_reset();
    check("rst_grant", {28'd0, grant}, 32'd0);
    check("rst_sel", {30'd0, sel}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_cnt", {16'd0, xfer_cnt}, 32'd0);

    // Reset mid-GRANT, with a prior word counted.
    d0 = 32'h1111_0000;
    req = 4'b0001;
    out_ready = 1'b1;
    push(4'b0001, 32'h1111_0000);
    tick();
    check("a_grant", {28'd0, grant}, 32'h1);
    tick();
    out_ready = 1'b0;
    check("a_idle_grant", {28'd0, grant}, 32'h0);
    tick();
    check("a_regrant", {28'd0, grant}, 32'h1);
    check("a_cnt1", {16'd0, xfer_cnt}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("a_async_grant", {28'd0, grant}, 32'h0);
    check("a_async_valid", {31'd0, out_valid}, 32'h0);
    check("a_async_ack", {28'd0, ack}, 32'h0);
    check("a_async_cnt", {16'd0, xfer_cnt}, 32'h0);
    tick();
    rst = 1'b0;
    d2 = 32'h2222_2222;
    req = 4'b0100;
    tick();
    check("a_sel2", {30'd0, sel}, 32'd2);
    check("a_grant2", {28'd0, grant}, 32'h4);
    check("a_valid2", {31'd0, out_valid}, 32'h1);

    // All requesting: rotation 0,1,2,3,0.
    do_reset();
    d0 = 32'hA0; d1 = 32'hA1; d2 = 32'hA2; d3 = 32'hA3;
    req = 4'b1111;
    out_ready = 1'b1;
    push(4'b0001, 32'hA0);
    push(4'b0010, 32'hA1);
    push(4'b0100, 32'hA2);
    push(4'b1000, 32'hA3);
    push(4'b0001, 32'hA0);
    tick();
    check("b_first_sel", {30'd0, sel}, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    req = 4'b0000;
    out_ready = 1'b0;
    check("b_cnt5", {16'd0, xfer_cnt}, 32'd5);
    check("b_next_sel", {30'd0, sel}, 32'd1);

    // Backpressure on requester 1.
    do_reset();
    d1 = 32'hDEAD_BEEF;
    req = 4'b0010;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("c_grant", {28'd0, grant}, 32'h2);
      check("c_dout", dout, 32'hDEAD_BEEF);
      check("c_ack", {28'd0, ack}, 32'h0);
      if (i < 2) tick();
    end
    out_ready = 1'b1;
    #1;
    check("c_ack_now", {28'd0, ack}, 32'h2);
    push(4'b0010, 32'hDEAD_BEEF);
    tick();
    check("c_ack_once", {28'd0, ack}, 32'h0);
    check("c_cnt", {16'd0, xfer_cnt}, 32'd1);
    req = 4'b0000;
    out_ready = 1'b0;

    // Single requester 3: a word every other cycle.
    do_reset();
    d3 = 32'h3333_3333;
    req = 4'b1000;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(4'b1000, 32'h3333_3333);
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("d_ack", {28'd0, ack}, (i % 2 == 1) ? 32'h8 : 32'h0);
    end
    check("d_cnt", {16'd0, xfer_cnt}, 32'd3);
    req = 4'b1001;
    out_ready = 1'b0;
    tick();
    check("d_ptr3_pick0", {28'd0, grant}, 32'h1);
    req = 4'b0000;

    // Withdrawal without ack.
    do_reset();
    req = 4'b0001;
    tick();
    check("e_grant", {28'd0, grant}, 32'h1);
    req = 4'b0000;
    #1;
    check("e_valid_drop", {31'd0, out_valid}, 32'h0);
    tick();
    check("e_idle", {28'd0, grant}, 32'h0);
    check("e_cnt", {16'd0, xfer_cnt}, 32'd0);
    req = 4'b0011;
    tick();
    check("e_repick0", {28'd0, grant}, 32'h1);
    check("e_sel0", {30'd0, sel}, 32'd0);
    req = 4'b0000;

`ifdef ARB_LOCK_EN
    // Burst lock on requester 0 for three words.
    do_reset();
    d0 = 32'hB0; d1 = 32'hB1;
    req = 4'b0011;
    lock = 4'b0001;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(4'b0001, 32'hB0);
    push(4'b0010, 32'hB1);
    tick();
    tick();
    tick();
    lock = 4'b0000;
    tick();
    check("f_grant1", {28'd0, grant}, 32'h2);
    tick();
    req = 4'b0000;
    out_ready = 1'b0;
    check("f_cnt", {16'd0, xfer_cnt}, 32'd4);
`endif

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    check("sb_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
